data_ram_master: RTL and testbench
==================================

// Module: data_ram_master
// PURPOSE
// Initiator-side controller driving the single-port DataRAM (din/addr/wr/en/dout).
// Clears every row through the write port after reset, then serves user read/write
// requests over a valid/ready handshake and returns read data with a response pulse.
// Sits between the datapath (user side) and the DataRAM (memory side).
// PARAMETERS
// C       32  data word width in bits
// AD      5   address width in bits; RAM depth = 2**AD rows
// RD_LAT  1   clock edges from the ram_en read edge until ram_dout is valid (1..4)
// PORTS
// clk        in   1   clock, all state updates on rising edge
// nrst       in   1   asynchronous active-low reset
// clr        in   1   synchronous pulse: restart the full clear sequence
// req_valid  in   1   user request present
// req_ready  out  1   controller accepts request this cycle
// req_wr     in   1   1 = write, 0 = read
// req_addr   in   AD  request row address
// req_wdata  in   C   write data
// rsp_valid  out  1   one-cycle pulse: rsp_rdata holds read data
// rsp_rdata  out  C   read data (holds value until next read response)
// init_done  out  1   1 once the clear sequence has completed
// ram_din    out  C   to RAM din
// ram_addr   out  AD  to RAM addr
// ram_wr     out  1   to RAM wr (1 = write)
// ram_en     out  1   to RAM en
// ram_dout   in   C   from RAM dout
// BEHAVIOUR
// - Reset (nrst=0, async): state=INIT, row counter=0, all registered outputs 0
//   (ram_en, ram_wr, ram_addr, ram_din, rsp_valid, rsp_rdata, init_done); any
//   in-flight read is discarded, no rsp_valid is ever issued for it.
// - All ram_* outputs, rsp_valid, rsp_rdata, init_done are registered. req_ready is
//   combinational: req_ready = (state==IDLE) & ~clr.
// - States: INIT, IDLE, RD_WAIT.
// - INIT: each edge drives ram_en=1, ram_wr=1, ram_din=0, ram_addr=counter, counter+1.
//   First edge after nrst release drives row 0; edge after row 2**AD-1 is driven:
//   ram_en=0, ram_wr=0, init_done=1, state=IDLE. init_done rises 2**AD+1 edges after
//   release. Counter terminates at all-ones, never wraps into a second pass.
//   clr and req_valid are ignored in INIT. Clear always covers all rows; a reset
//   during INIT restarts from row 0.
// - IDLE, accept write (req_valid&req_ready, req_wr=1): next cycle ram_en=1, ram_wr=1,
//   ram_addr=req_addr, ram_din=req_wdata for exactly one cycle. Stay IDLE; back-to-back
//   writes sustain one per cycle. No response for writes.
// - IDLE, accept read (req_wr=0): next cycle ram_en=1, ram_wr=0, ram_addr=req_addr for
//   one cycle; ram_din holds last value; state=RD_WAIT, req_ready=0.
// - RD_WAIT: count RD_LAT edges after the ram_en read edge, then sample ram_dout into
//   rsp_rdata; rsp_valid=1 for the following single cycle and state=IDLE in that same
//   cycle (req_ready may be 1 while rsp_valid=1). One outstanding read maximum.
// - Read latency: rsp_valid first high RD_LAT+2 edges after the accepting edge.
// - clr in IDLE: counter=0, init_done=0, state=INIT next edge; clr wins over a
//   simultaneous req_valid (request not accepted). clr in RD_WAIT is held off: read
//   completes, then INIT starts if clr is high in the IDLE cycle.
// - ram_en=0 in every cycle not listed above; ram_wr=0 whenever ram_en=0.
// TESTING
// T1 release nrst, hold req_valid=1 -> req_ready=0 for 33 edges, 32 writes of 0 to
//    rows 0..31 in order, init_done=1 at edge 33, RAM all zero.
// T2 write 50@2, then read @2 -> ram_en/wr=1/1 one cycle; read rsp_valid one pulse
//    at RD_LAT+2 edges after accept with rsp_rdata=50; read @30 returns 0.
// T3 back-to-back writes 167@16, 205@30 on consecutive cycles -> both accepted with
//    req_ready=1 each cycle; reads return 167 and 205.
// T4 nrst low 20 edges into INIT, release -> ram_en=0 immediately, clear restarts at
//    row 0, full 32 rows cleared; row 30 previously 205 reads 0.
// T5 issue read @16, assert nrst=0 before rsp_valid -> no rsp_valid, rsp_rdata=0,
//    state INIT after release.
// T6 clr=1 with req_valid=1 (write 7@3) in IDLE -> request not accepted, init_done
//    drops next edge, 32-row clear runs, row 3 reads 0.

Source files
------------

// File: rtl/data_ram_master.sv
// rtl/data_ram_master.sv - DataRAM initiator: post-reset row clear, then user read/write service
module data_ram_master #(
   parameter int C      = 32,
   parameter int AD     = 5,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          clr,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_wr,
   input  logic [AD-1:0] req_addr,
   input  logic [C-1:0]  req_wdata,
   output logic          rsp_valid,
   output logic [C-1:0]  rsp_rdata,
   output logic          init_done,
   output logic [C-1:0]  ram_din,
   output logic [AD-1:0] ram_addr,
   output logic          ram_wr,
   output logic          ram_en,
   input  logic [C-1:0]  ram_dout
);

   typedef enum logic [1:0] {INIT, IDLE, RD_WAIT} state_t;

   // Response edge counted from the accepting edge: read edge, RD_LAT data edges, sample edge
   localparam logic [2:0] RSP_EDGE = 3'(RD_LAT + 1);

   state_t      state;
   logic [AD:0] row_cnt;
   logic [2:0]  lat_cnt;

   assign req_ready = (state == IDLE) & ~clr;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= INIT;
         row_cnt   <= '0;
         lat_cnt   <= '0;
         ram_en    <= 1'b0;
         ram_wr    <= 1'b0;
         ram_addr  <= '0;
         ram_din   <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         init_done <= 1'b0;
      end else begin
         ram_en    <= 1'b0;
         ram_wr    <= 1'b0;
         rsp_valid <= 1'b0;
         case (state)
            INIT: begin
               // Top bit of row_cnt marks that the last row has already been driven
               if (row_cnt[AD]) begin
                  init_done <= 1'b1;
                  state     <= IDLE;
               end else begin
                  ram_en   <= 1'b1;
                  ram_wr   <= 1'b1;
                  ram_din  <= '0;
                  ram_addr <= row_cnt[AD-1:0];
                  row_cnt  <= row_cnt + (AD+1)'(1);
               end
            end
            IDLE: begin
               if (clr) begin
                  row_cnt   <= '0;
                  init_done <= 1'b0;
                  state     <= INIT;
               end else if (req_valid) begin
                  ram_en   <= 1'b1;
                  ram_wr   <= req_wr;
                  ram_addr <= req_addr;
                  if (req_wr) begin
                     ram_din <= req_wdata;
                  end else begin
                     lat_cnt <= '0;
                     state   <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               if (lat_cnt == RSP_EDGE) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= ram_dout;
                  state     <= IDLE;
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_data_ram_master.sv
// tb/tb_data_ram_master.sv - self-checking bench for data_ram_master against a shadow-memory model
module tb_data_ram_master;

   localparam int C      = 32;
   localparam int AD     = 5;
   localparam int RD_LAT = 1;
   localparam int ROWS   = 1 << AD;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          clr = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_wr = 1'b0;
   logic [AD-1:0] req_addr = '0;
   logic [C-1:0]  req_wdata = '0;
   logic          rsp_valid;
   logic [C-1:0]  rsp_rdata;
   logic          init_done;
   logic [C-1:0]  ram_din;
   logic [AD-1:0] ram_addr;
   logic          ram_wr;
   logic          ram_en;
   logic [C-1:0]  ram_dout = '0;

   logic          fill = 1'b0;
   logic [C-1:0]  mem [ROWS];
   logic [C-1:0]  ref_mem [ROWS];

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit          wr;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t vt [8];

   data_ram_master #(.C(C), .AD(AD), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .nrst(nrst), .clr(clr),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
      .ram_din(ram_din), .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_en(ram_en),
      .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // Single-port RAM with one-edge read latency; fill preloads nonzero garbage
   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < ROWS; i++) mem[i] <= 32'hA5A5_0000 | i;
      end else if (ram_en) begin
         if (ram_wr) mem[ram_addr] <= ram_din;
         else        ram_dout <= mem[ram_addr];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 100) begin
         tick();
         n++;
      end
      if (!req_ready) check("ready_timeout", 0, 1);
   endtask

   // Expect a full clear starting on the next edge; called at a sample point
   task automatic run_clear();
      int bad_rdy = 0, bad_ctl = 0, bad_addr = 0, bad_mem = 0;
      for (int k = 1; k <= ROWS + 1; k++) begin
         if (req_ready) bad_rdy++;
         tick();
         if (k <= ROWS) begin
            if (!(ram_en && ram_wr && ram_din == 0 && !init_done)) bad_ctl++;
            if (int'(ram_addr) != k - 1) bad_addr++;
         end
      end
      req_valid = 1'b0;
      check("clear_ready_low", bad_rdy, 0);
      check("clear_ctl", bad_ctl, 0);
      check("clear_row_order", bad_addr, 0);
      check("clear_init_done", init_done, 1);
      check("clear_en_off", {ram_en, ram_wr}, 0);
      check("clear_ready_after", req_ready, 1);
      tick();
      for (int i = 0; i < ROWS; i++) if (mem[i] != 0) bad_mem++;
      check("clear_ram_zero", bad_mem, 0);
      for (int i = 0; i < ROWS; i++) ref_mem[i] = '0;
   endtask

   task automatic do_write(input logic [AD-1:0] a, input logic [C-1:0] d);
      wait_ready();
      req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d;
      tick();
      req_valid = 1'b0;
      check("wr_cmd", {ram_en, ram_wr, ram_addr}, {2'b11, a});
      check("wr_data", ram_din, d);
      ref_mem[a] = d;
   endtask

   task automatic do_read(input logic [AD-1:0] a, input logic [C-1:0] exp);
      int n = 0;
      wait_ready();
      req_valid = 1'b1; req_wr = 1'b0; req_addr = a;
      tick();
      req_valid = 1'b0;
      check("rd_cmd", {ram_en, ram_wr, ram_addr}, {2'b10, a});
      while (!rsp_valid && n < 12) begin
         tick();
         n++;
         if (n == 1) check("rd_busy", {req_ready, ram_en}, 0);
      end
      check("rd_latency", n, RD_LAT + 2);
      check("rd_data", rsp_rdata, exp);
      check("rd_ready_on_rsp", req_ready, 1);
      tick();
      check("rd_pulse", rsp_valid, 0);
   endtask

   initial begin
      vt[0] = '{1'b1, 5'd2,  32'd50,         32'd0};
      vt[1] = '{1'b0, 5'd2,  32'd0,          32'd50};
      vt[2] = '{1'b0, 5'd30, 32'd0,          32'd0};
      vt[3] = '{1'b1, 5'd0,  32'd9,          32'd0};
      vt[4] = '{1'b1, 5'd31, 32'hFFFF_FFFF,  32'd0};
      vt[5] = '{1'b0, 5'd0,  32'd0,          32'd9};
      vt[6] = '{1'b0, 5'd31, 32'd0,          32'hFFFF_FFFF};
      vt[7] = '{1'b0, 5'd1,  32'd0,          32'd0};

      // Reset state, with RAM preloaded so the clear is observable
      fill = 1'b1;
      tick();
      fill = 1'b0;
      tick();
      check("reset_outputs", {ram_en, ram_wr, ram_addr, ram_din, rsp_valid, rsp_rdata, init_done},
            '0);
      check("reset_ready", req_ready, 0);

      // T1: release with req_valid held high
      nrst = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_addr = 5'd7; req_wdata = 32'h1234;
      run_clear();

      // T2 and friends: table-driven
      foreach (vt[i]) begin
         if (vt[i].wr) do_write(vt[i].addr, vt[i].data);
         else          do_read(vt[i].addr, vt[i].exp);
      end

      // T3: back-to-back writes
      wait_ready();
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 5'd16; req_wdata = 32'd167;
      check("b2b_ready0", req_ready, 1);
      tick();
      check("b2b_w0", {ram_en, ram_wr, ram_addr, ram_din}, {2'b11, 5'd16, 32'd167});
      req_addr = 5'd30; req_wdata = 32'd205;
      check("b2b_ready1", req_ready, 1);
      tick();
      req_valid = 1'b0;
      check("b2b_w1", {ram_en, ram_wr, ram_addr, ram_din}, {2'b11, 5'd30, 32'd205});
      do_read(5'd16, 32'd167);
      do_read(5'd30, 32'd205);

      // T4: reset 20 edges into a clear
      nrst = 1'b0;
      tick();
      nrst = 1'b1;
      repeat (20) tick();
      nrst = 1'b0;
      #1;
      check("rst_mid_clear", {ram_en, ram_wr, init_done}, 0);
      repeat (2) tick();
      nrst = 1'b1;
      run_clear();
      do_read(5'd30, 32'd0);

      // T5: reset while a read is outstanding
      do_write(5'd16, 32'd77);
      do_read(5'd16, 32'd77);
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 5'd16;
      tick();
      req_valid = 1'b0;
      nrst = 1'b0;
      begin
         int seen = 0;
         repeat (4) begin
            tick();
            if (rsp_valid) seen++;
         end
         check("abort_no_rsp", seen, 0);
         check("abort_rdata", rsp_rdata, 0);
      end
      nrst = 1'b1;
      run_clear();

      // T6: clr beats a simultaneous write
      do_write(5'd3, 32'd11);
      clr = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_addr = 5'd3; req_wdata = 32'd7;
      #0;
      check("clr_ready_low", req_ready, 0);
      tick();
      check("clr_no_accept", ram_en, 0);
      check("clr_init_drop", init_done, 0);
      clr = 1'b0; req_valid = 1'b0;
      run_clear();
      do_read(5'd3, 32'd0);

      // Randomized traffic against the shadow memory
      for (int i = 0; i < 80; i++) begin
         logic [AD-1:0] a;
         a = AD'($urandom_range(0, ROWS - 1));
         if ($urandom_range(0, 1) == 1) do_write(a, C'($urandom));
         else                           do_read(a, ref_mem[a]);
         if ($urandom_range(0, 3) == 0) tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
